fp32_sqrt_arbiter: RTL and testbench

//  Shares one free-running fp32_sqrt pipeline (fixed latency, no stall input) between NUM_REQ requesters.

---
 rtl/fp32_sqrt_pkg.sv | 22 ++
 rtl/sqrt_rsp_fifo.sv | 50 +++++
 rtl/fp32_sqrt_arbiter.sv | 130 +++++++++++++
 tb/tb_fp32_sqrt_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_sqrt_pkg.sv
// Shared types and constants for the fp32 square-root arbiter slice.
package fp32_sqrt_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } rm_e;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

    // Must be at least $clog2(NUM_REQ) of the arbiter using it.
    localparam int SQRT_TAG_W = 2;

    typedef struct packed {
        logic [SQRT_TAG_W-1:0] tag;
        logic [31:0]           result;
    } sqrt_rsp_t;

endpackage

// File: rtl/sqrt_rsp_fifo.sv
// Response FIFO for the sqrt arbiter: DEPTH entries of sqrt_rsp_t, registered output, no fall-through.
module sqrt_rsp_fifo
    import fp32_sqrt_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  sqrt_rsp_t        push_data,
    input  logic             pop,
    output sqrt_rsp_t        head,
    output logic [CNT_W-1:0] count
);

    sqrt_rsp_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp32_sqrt_arbiter.sv
// Round-robin sharing of one fixed-latency fp32_sqrt pipe with tag tracking and a credit-protected response FIFO.
// Optional FP32_SQRT_ARB_STATS_EN adds stat_issue / stat_stall counters.
module fp32_sqrt_arbiter
    import fp32_sqrt_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int LATENCY    = 5,
    parameter  int FIFO_DEPTH = 8,
    localparam int TAG_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*2-1:0] req_rm,
    output logic [31:0]          sq_a,
    output logic [1:0]           sq_rm,
    input  logic [31:0]          sq_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_result,
    output logic                 busy
`ifdef FP32_SQRT_ARB_STATS_EN
    ,
    output logic [31:0]          stat_issue,
    output logic [31:0]          stat_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [TAG_W-1:0] last_grant;
    logic [TAG_W-1:0] gnt_idx;
    logic [TAG_W-1:0] idx;
    logic             issue;
    logic             credit;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic [LATENCY:0] stg_v;
    logic [TAG_W-1:0] stg_tag [LATENCY+1];
    sqrt_rsp_t        push_data;
    sqrt_rsp_t        head;

    // Ops in the tag pipe already own a FIFO slot, so the FIFO can never overflow.
    assign in_flight = CNT_W'($countones(stg_v));
    assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit    = rst_n && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        issue   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (credit) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = TAG_W'((32'(last_grant) + k) % NUM_REQ);
                if (!issue && req_valid[idx]) begin
                    issue   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_a       <= '0;
            sq_rm      <= '0;
            last_grant <= TAG_W'(NUM_REQ - 1);
        end else if (issue) begin
            sq_a       <= req_a[32*gnt_idx +: 32];
            sq_rm      <= req_rm[2*gnt_idx +: 2];
            last_grant <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) stg_tag[i] <= '0;
        end else begin
            stg_v      <= {stg_v[LATENCY-1:0], issue};
            stg_tag[0] <= gnt_idx;
            for (int unsigned i = 1; i <= LATENCY; i++) stg_tag[i] <= stg_tag[i-1];
        end
    end

    always_comb begin
        push_data        = '0;
        push_data.tag    = SQRT_TAG_W'(stg_tag[LATENCY]);
        push_data.result = sq_result;
    end

    sqrt_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stg_v[LATENCY]),
        .push_data (push_data),
        .pop       (rsp_valid && rsp_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp_valid  = (fifo_count != '0);
    assign rsp_tag    = rsp_valid ? TAG_W'(head.tag) : '0;
    assign rsp_result = rsp_valid ? head.result : '0;
    assign busy       = (in_flight != '0) || (fifo_count != '0);

`ifdef FP32_SQRT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (issue)                   stat_issue <= stat_issue + 32'd1;
            if ((|req_valid) && !credit) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_sqrt_arbiter.sv
// Scoreboard bench for fp32_sqrt_arbiter with a behavioural fixed-latency sqrt pipe.
module tb_fp32_sqrt_arbiter;
    import fp32_sqrt_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int LATENCY    = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int TAG_W      = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*2-1:0]  req_rm;
    logic [31:0]           sq_a;
    logic [1:0]            sq_rm;
    logic [31:0]           sq_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_result;
    logic                  busy;
`ifdef FP32_SQRT_ARB_STATS_EN
    logic [31:0]           stat_issue;
    logic [31:0]           stat_stall;
`endif

    always #5 clk = ~clk;

    fp32_sqrt_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_rm     (req_rm),
        .sq_a       (sq_a),
        .sq_rm      (sq_rm),
        .sq_result  (sq_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef FP32_SQRT_ARB_STATS_EN
        ,
        .stat_issue (stat_issue),
        .stat_stall (stat_stall)
`endif
    );

    // Stand-in sqrt unit: exact for the directed operands, a cheap rm-dependent mapping otherwise.
    function automatic logic [31:0] sqrt_model(input logic [31:0] a, input logic [1:0] rm);
        case (a)
            32'h3F80_0000: return FP32_ONE;
            32'h4080_0000: return 32'h4000_0000;
            32'h0000_0000: return 32'h0000_0000;
            32'hBF80_0000: return FP32_QNAN;
            32'h7F80_0000: return 32'h7F80_0000;
            default:       return ((a >> 1) + 32'h1FC0_0000) ^ {30'b0, rm};
        endcase
    endfunction

    logic [31:0] pa  [LATENCY];
    logic [1:0]  prm [LATENCY];
    initial for (int i = 0; i < LATENCY; i++) begin pa[i] = '0; prm[i] = '0; end
    always @(posedge clk) begin
        pa[0]  <= sq_a;
        prm[0] <= sq_rm;
        for (int i = 1; i < LATENCY; i++) begin
            pa[i]  <= pa[i-1];
            prm[i] <= prm[i-1];
        end
    end
    assign sq_result = sqrt_model(pa[LATENCY-1], prm[LATENCY-1]);

    typedef struct { logic [TAG_W-1:0] tag; logic [31:0] res; } exp_t;
    exp_t sb[$];
    int   gq[$];
    exp_t e;
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, n_issue = 0, n_stall = 0, n_rsp = 0;
    logic stall_prev = 1'b0;
    logic [TAG_W-1:0] prev_tag;
    logic [31:0] prev_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_tag", rsp_tag, prev_tag);
                check("rsp_hold_result", rsp_result, prev_res);
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_tag   = rsp_tag;
            prev_res   = rsp_result;
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_result", rsp_result, e.res);
                end
                n_rsp++;
            end
            check("ready_onehot", $countones(req_ready) <= 1, 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{tag: TAG_W'(i), res: sqrt_model(req_a[32*i +: 32], req_rm[2*i +: 2])});
                    gq.push_back(i);
                    n_issue++;
                end
            end
            if ((|req_valid) && (req_ready == '0)) n_stall++;
        end
    end

    task automatic check_reset(input string p);
        check({p, "_req_ready"}, req_ready, 0);
        check({p, "_sq_a"}, sq_a, 0);
        check({p, "_sq_rm"}, sq_rm, 0);
        check({p, "_rsp_valid"}, rsp_valid, 0);
        check({p, "_rsp_tag"}, rsp_tag, 0);
        check({p, "_rsp_result"}, rsp_result, 0);
        check({p, "_busy"}, busy, 0);
    endtask

    task automatic wait_idle(input string p);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check({p, "_busy"}, busy, 0);
        check({p, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        gq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic reroll(input logic [NUM_REQ-1:0] g);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) begin
                req_a[32*i +: 32] = $urandom;
                req_rm[2*i +: 2]  = 2'($urandom_range(3));
            end
        end
    endtask

    logic [NUM_REQ-1:0] g;
    int gcyc, iters, base_issue, base_stall, base_rsp;
`ifdef FP32_SQRT_ARB_STATS_EN
    logic [31:0] s_issue0, s_stall0;
`endif

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_rm = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset("rst");
        rst_n = 1'b1;

        // T1: single op, latency from grant to rsp_valid
        @(posedge clk); #1;
        req_a[31:0] = 32'h3F80_0000; req_rm[1:0] = RNE; req_valid = 4'b0001;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        check("t1_grant", req_ready[0], 1);
        gcyc = cyc;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("t1_sq_a", sq_a, 32'h3F80_0000);
        check("t1_sq_rm", sq_rm, RNE);
        check("t1_busy", busy, 1);
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_latency", cyc - gcyc, LATENCY + 2);
        wait_idle("t1");

        // T2: all four at once, grants 0..3 back-to-back, special-value results
        do_reset();
        req_a = {32'h7F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4080_0000};
        req_rm = '0;
        req_valid = 4'hF;
        iters = 0;
        for (int k = 0; k < 50 && req_valid != '0; k++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            iters++;
            @(posedge clk); #1 req_valid &= ~g;
        end
        check("t2_all_granted", req_valid, 0);
        check("t2_back_to_back", iters, 4);
        check("t2_grant_count", gq.size(), 4);
        for (int j = 0; j < 4 && j < gq.size(); j++) check("t2_grant_order", gq[j], j);
        wait_idle("t2");

        // T3: req1 and req3 continuously valid must alternate
        gq.delete();
        reroll(4'b1010);
        req_valid = 4'b1010;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            if (gq.size() >= 20) break;
            @(posedge clk); #1 reroll(g);
        end
        @(posedge clk); #1 req_valid = '0;
        check("t3_issue_count", gq.size() >= 20, 1);
        for (int j = 0; j < 20 && j < gq.size(); j++) check("t3_alternate", gq[j], (j % 2 == 0) ? 1 : 3);
        wait_idle("t3");

        // T4: consumer stalled, credit caps issues at FIFO_DEPTH, then drain
        base_issue = n_issue; base_stall = n_stall; base_rsp = n_rsp;
`ifdef FP32_SQRT_ARB_STATS_EN
        s_issue0 = stat_issue; s_stall0 = stat_stall;
`endif
        rsp_ready = 1'b0;
        reroll(4'hF);
        req_valid = 4'hF;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk); #1 reroll(g);
        end
        @(negedge clk);
        check("t4_issue_cap", n_issue - base_issue, FIFO_DEPTH);
        check("t4_blocked", req_ready, 0);
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_busy", busy, 1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            g = req_ready & req_valid;
            if (n_issue - base_issue >= 24) break;
            @(posedge clk); #1 reroll(g);
        end
        @(posedge clk); #1 req_valid = '0;
        check("t4_resumed", n_issue - base_issue >= 24, 1);
        wait_idle("t4");
        check("t4_rsp_count", n_rsp - base_rsp, n_issue - base_issue);
`ifdef FP32_SQRT_ARB_STATS_EN
        check("t6_stat_issue", stat_issue - s_issue0, n_issue - base_issue);
        check("t6_stat_stall", stat_stall - s_stall0, n_stall - base_stall);
`endif

        // T5: reset with three ops in flight
        base_issue = n_issue;
        req_valid = 4'hF;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (n_issue - base_issue >= 3) break;
        end
        check("t5_three_issued", n_issue - base_issue, 3);
        @(posedge clk); #1;
        check("t5_busy_before", busy, 1);
        req_valid = '0;
        rst_n = 1'b0;
        #1 check_reset("t5");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < LATENCY + 10; k++) begin
            @(negedge clk);
            check("t5_no_rsp", rsp_valid, 0);
        end
        check("t5_busy_after", busy, 0);

        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
